// File: rtl/comparator_d_pkg.sv
// ---------------------------------------------------------------------------
// comparator_d_pkg
// Shared definitions for the comparator_d magnitude comparator:
//   - default operand width and slice width
//   - slice_res_t : per-slice comparison record {gt, eq}
//   - slice_count : number of slices needed to cover an operand
//   - merge_res   : combines a more-significant and a less-significant record
// ---------------------------------------------------------------------------
package comparator_d_pkg;

   localparam int MSB_DEFAULT   = 256;
   localparam int CHUNK_DEFAULT = 16;

   typedef struct packed {
      logic gt;
      logic eq;
   } slice_res_t;

   function automatic int slice_count(input int msb, input int chunk);
      return (msb + chunk - 1) / chunk;
   endfunction

   // The more-significant record decides unless its slices are equal.
   function automatic slice_res_t merge_res(input slice_res_t hi, input slice_res_t lo);
      return hi.eq ? lo : hi;
   endfunction

endpackage

// File: rtl/comparator_d_chunk.sv
// ---------------------------------------------------------------------------
// comparator_d_chunk
// Leaf comparator for one CHUNK-bit slice. Purely combinational, unsigned.
// Ports:
//   a, b : CHUNK-bit slice operands
//   gt   : a > b
//   eq   : a == b
// ---------------------------------------------------------------------------
module comparator_d_chunk
#(
   parameter int CHUNK = 16
)
(
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             gt,
   output logic             eq
);

   assign gt = (a > b);
   assign eq = (a == b);

endmodule

// File: rtl/comparator_d.sv
// ---------------------------------------------------------------------------
// comparator_d
// Registered magnitude comparator. Operands are split into CHUNK-bit slices,
// each slice is compared by comparator_d_chunk, and the per-slice records are
// folded by a balanced tree in which the more-significant side wins unless it
// is equal. One result per cycle, latency one cycle.
//
// Configuration macro: COMPARATOR_D_SIGNED_EN
//   defined   : two's-complement comparison (bit MSB-1 is the sign)
//   undefined : unsigned comparison
//
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears all three flags
//   a, b    : MSB-bit operands
//   greater : registered a > b
//   less    : registered a < b
//   equal   : registered a == b
// ---------------------------------------------------------------------------
module comparator_d
   import comparator_d_pkg::*;
#(
   parameter int MSB   = MSB_DEFAULT,
   parameter int CHUNK = CHUNK_DEFAULT
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic [MSB-1:0] a,
   input  logic [MSB-1:0] b,
   output logic           greater,
   output logic           less,
   output logic           equal
);

   localparam int NSL = slice_count(MSB, CHUNK);
   localparam int W   = NSL * CHUNK;
   localparam int LVL = (NSL > 1) ? $clog2(NSL) : 0;
   localparam int P   = 1 << LVL;

   // Stage p0: operand extension to a whole number of slices
   logic [W-1:0] a_key;
   logic [W-1:0] b_key;

`ifdef COMPARATOR_D_SIGNED_EN
   // Sign-extend, then invert the top bit: this maps two's-complement order
   // onto unsigned order, so the slice comparators stay unsigned.
   localparam logic [W-1:0] SIGN_FLIP = W'(1) << (W - 1);
   logic signed [MSB-1:0] a_s;
   logic signed [MSB-1:0] b_s;
   logic signed [W-1:0]   a_sx;
   logic signed [W-1:0]   b_sx;

   assign a_s   = $signed(a);
   assign b_s   = $signed(b);
   assign a_sx  = W'(a_s);
   assign b_sx  = W'(b_s);
   assign a_key = a_sx ^ SIGN_FLIP;
   assign b_key = b_sx ^ SIGN_FLIP;
`else
   assign a_key = W'(a);
   assign b_key = W'(b);
`endif

   // Leaf comparisons; slots beyond NSL are padded with a neutral "equal"
   // record so the tree can be a full power of two.
   logic [P-1:0] leaf_gt;
   logic [P-1:0] leaf_eq;

   for (genvar i = 0; i < P; i++) begin : g_leaf
      if (i < NSL) begin : g_cmp
         comparator_d_chunk #(
            .CHUNK (CHUNK)
         ) u_chunk (
            .a  (a_key[i*CHUNK +: CHUNK]),
            .b  (b_key[i*CHUNK +: CHUNK]),
            .gt (leaf_gt[i]),
            .eq (leaf_eq[i])
         );
      end else begin : g_pad
         assign leaf_gt[i] = 1'b0;
         assign leaf_eq[i] = 1'b1;
      end
   end

   // Heap-ordered merge tree: leaf for slice i sits at P-1+i, node k has
   // the less-significant child at 2k+1 and the more-significant at 2k+2.
   slice_res_t node [2*P-1];
   slice_res_t root;

   always_comb begin
      for (int i = 0; i < 2*P-1; i++) begin
         node[i] = '{gt: 1'b0, eq: 1'b1};
      end
      for (int i = 0; i < P; i++) begin
         node[P-1+i] = '{gt: leaf_gt[i], eq: leaf_eq[i]};
      end
      for (int k = P - 2; k >= 0; k--) begin
         node[k] = merge_res(node[2*k+2], node[2*k+1]);
      end
      root = node[0];
   end

   // Stage p0 -> p1: output register
   always_ff @(posedge clk) begin
      if (rst) begin
         greater <= 1'b0;
         less    <= 1'b0;
         equal   <= 1'b0;
      end else begin
         greater <= root.gt;
         less    <= ~root.gt & ~root.eq;
         equal   <= root.eq;
      end
   end

endmodule

// File: tb/tb_comparator_d.sv
// ---------------------------------------------------------------------------
// tb_comparator_d
// Directed testbench for comparator_d. Two instances: the default 256/16
// configuration and an 8/3 configuration with a partial top slice.
// ---------------------------------------------------------------------------
module tb_comparator_d;

   localparam int W  = 256;
   localparam int W8 = 8;

   localparam logic [2:0] GT = 3'b100;
   localparam logic [2:0] LT = 3'b010;
   localparam logic [2:0] EQ = 3'b001;
   localparam logic [2:0] Z3 = 3'b000;

   logic          clk;
   logic          rst;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          greater;
   logic          less;
   logic          equal;
   logic [W8-1:0] a8;
   logic [W8-1:0] b8;
   logic          greater8;
   logic          less8;
   logic          equal8;

   int errors = 0;
   int checks = 0;

   comparator_d #(
      .MSB   (W),
      .CHUNK (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .greater (greater),
      .less    (less),
      .equal   (equal)
   );

   comparator_d #(
      .MSB   (W8),
      .CHUNK (3)
   ) dut8 (
      .clk     (clk),
      .rst     (rst),
      .a       (a8),
      .b       (b8),
      .greater (greater8),
      .less    (less8),
      .equal   (equal8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge; outputs are sampled at
   // the same point, i.e. just after the edge that registered them.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a = '0; b = '0; a8 = '0; b8 = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({greater, less, equal} !== Z3) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %b expected %b", i, {greater, less, equal}, Z3);
         end
         checks++;
         if ({greater8, less8, equal8} !== Z3) begin
            errors++;
            $display("FAIL reset_hold8[%0d]: got %b expected %b", i, {greater8, less8, equal8}, Z3);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({greater, less, equal} !== EQ) begin
         errors++;
         $display("FAIL reset_release: got %b expected %b", {greater, less, equal}, EQ);
      end
      checks++;
      if ({greater8, less8, equal8} !== EQ) begin
         errors++;
         $display("FAIL reset_release8: got %b expected %b", {greater8, less8, equal8}, EQ);
      end
   endtask

   task automatic test_top_slice();
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      logic [2:0]   ex [3];
      va[0] = {4'hA, 252'd0}; vb[0] = {4'hD, 252'd0}; ex[0] = LT;
      va[1] = {4'hE, 252'd0}; vb[1] = {4'hC, 252'd0}; ex[1] = GT;
      va[2] = {4'hD, 252'd0}; vb[2] = {4'hF, 252'd0}; ex[2] = LT;
      for (int i = 0; i < 3; i++) begin
         a = va[i]; b = vb[i];
         tick();
         checks++;
         if ({greater, less, equal} !== ex[i]) begin
            errors++;
            $display("FAIL top_slice[%0d]: got %b expected %b", i, {greater, less, equal}, ex[i]);
         end
      end
   endtask

   task automatic test_low_slices();
      logic [W-1:0] va [4];
      logic [W-1:0] vb [4];
      logic [2:0]   ex [4];
      va[0] = 256'd1;          vb[0] = 256'd0;          ex[0] = GT;
      va[1] = '1;             vb[1] = '1;             ex[1] = EQ;
      va[2] = 256'd1 << 99;   vb[2] = 256'd1 << 100;  ex[2] = LT;
      va[3] = {16'h1234, 224'd0, 16'h0005};
      vb[3] = {16'h1234, 224'd0, 16'h0004};           ex[3] = GT;
      for (int i = 0; i < 4; i++) begin
         a = va[i]; b = vb[i];
         tick();
         checks++;
         if ({greater, less, equal} !== ex[i]) begin
            errors++;
            $display("FAIL low_slices[%0d]: got %b expected %b", i, {greater, less, equal}, ex[i]);
         end
      end
   endtask

   task automatic test_sign();
      logic [2:0] ex;
`ifdef COMPARATOR_D_SIGNED_EN
      ex = LT;
`else
      ex = GT;
`endif
      a = 256'd1 << 255; b = 256'd1;
      tick();
      checks++;
      if ({greater, less, equal} !== ex) begin
         errors++;
         $display("FAIL sign_bit: got %b expected %b", {greater, less, equal}, ex);
      end
   endtask

   task automatic test_back_to_back();
      logic [W8-1:0] va [4];
      logic [W8-1:0] vb [4];
      logic [2:0]    ex [4];
      logic [2:0]    o;
      va[0] = 8'd5;   vb[0] = 8'd3;   ex[0] = GT;
      va[1] = 8'd3;   vb[1] = 8'd5;   ex[1] = LT;
      va[2] = 8'd7;   vb[2] = 8'd7;   ex[2] = EQ;
      va[3] = 8'h40;  vb[3] = 8'h3F;  ex[3] = GT;
      for (int i = 0; i < 4; i++) begin
         a8 = va[i]; b8 = vb[i];
         tick();
         o = {greater8, less8, equal8};
         checks++;
         if (o !== ex[i]) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got %b expected %b", i, o, ex[i]);
         end
         checks++;
         if ($countones(o) != 1) begin
            errors++;
            $display("FAIL one_hot[%0d]: got %b expected exactly one bit set", i, o);
         end
      end
   endtask

   task automatic test_reset_midstream();
      a = 256'd9; b = 256'd2; a8 = 8'd1; b8 = 8'd2;
      rst = 1'b1;
      tick();
      checks++;
      if ({greater, less, equal} !== Z3) begin
         errors++;
         $display("FAIL mid_reset: got %b expected %b", {greater, less, equal}, Z3);
      end
      checks++;
      if ({greater8, less8, equal8} !== Z3) begin
         errors++;
         $display("FAIL mid_reset8: got %b expected %b", {greater8, less8, equal8}, Z3);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({greater, less, equal} !== GT) begin
         errors++;
         $display("FAIL mid_reset_resume: got %b expected %b", {greater, less, equal}, GT);
      end
      checks++;
      if ({greater8, less8, equal8} !== LT) begin
         errors++;
         $display("FAIL mid_reset_resume8: got %b expected %b", {greater8, less8, equal8}, LT);
      end
   endtask

   initial begin
      rst = 1'b1;
      a = '0; b = '0; a8 = '0; b8 = '0;
      #2;
      test_reset();
      test_top_slice();
      test_low_slices();
      test_sign();
      test_back_to_back();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/comparator_d.md
COMPARATOR_D -- requirements
Module: comparator_d

Interface
- REQ-001: Parameter `MSB`, default 256: operand width in bits; legal range 1..1024.
- REQ-002: Parameter `CHUNK`, default 16: slice width of each leaf comparison; legal range 1..`MSB`.
- REQ-003: `clk`, input, 1 bit: the single clock; every register updates on its rising edge.
- REQ-004: `rst`, input, 1 bit: reset, synchronous and active-high.
- REQ-005: `a`, input, `MSB` bits: first operand.
- REQ-006: `b`, input, `MSB` bits: second operand.
- REQ-007: `greater`, output, 1 bit: registered flag, high when a > b.
- REQ-008: `less`, output, 1 bit: registered flag, high when a < b.
- REQ-009: `equal`, output, 1 bit: registered flag, high when a == b.

Function
- REQ-010: The block SHALL sample `a` and `b` on each rising edge of `clk` when `rst` is low, and present the result on the outputs after that edge (latency exactly 1 cycle).
- REQ-011: Outside reset, exactly one of `greater`, `less` and `equal` SHALL be high.
- REQ-012: By default the comparison SHALL be unsigned magnitude over all `MSB` bits.
- REQ-013: The comparison SHALL be computed as follows:
  - split both operands into ceil(`MSB`/`CHUNK`) slices;
  - each slice produces gt/eq flags;
  - merge the flags with a balanced tree in which the more-significant slice dominates unless its eq flag is set.
- REQ-014: If `MSB` is not a multiple of `CHUNK`, the top slice SHALL be zero-extended (sign-extended when REQ-019 applies).
- REQ-015: There SHALL be no handshake; a new operand pair is accepted every cycle, giving a throughput of 1 result per cycle.
- REQ-016: Operands that change on consecutive cycles SHALL yield consecutive independent results with no carry-over of state.

Reset
- REQ-017: While `rst` is high at a rising edge, `greater`, `less` and `equal` SHALL all be 0 on the following cycle.
- REQ-018: The first valid result SHALL appear one cycle after the first edge at which `rst` is low. If `rst` is asserted mid-stream, the pending result is discarded.

Configuration
- REQ-019: Macro `COMPARATOR_D_SIGNED_EN`:
  - defined: operands are two's complement, and bit `MSB`-1 is the sign bit (negative < positive);
  - undefined: unsigned comparison per REQ-012.
  - Port list and latency SHALL be identical in both builds.

Structure
- REQ-020: Package `comparator_d_pkg` SHALL hold:
  - default constants for `MSB` (256) and `CHUNK` (16);
  - a typedef for the per-slice result record {gt, eq};
  - the function computing the slice count.
- REQ-021: The leaf slice comparator SHALL be a sub-module named `comparator_d_chunk`, with inputs of `CHUNK`-bit a/b and outputs gt and eq. The top level SHALL instantiate it via a generate loop and implement the merge tree and output registers.

Verification
- REQ-022: Reset: hold `rst`=1 for 3 cycles with a=b=0 -> all outputs 0; release `rst` -> next cycle `equal`=1 and `greater`=`less`=0.
- REQ-023: MSB=256, a=0xA followed by 252 zeros, b=0xD followed by 252 zeros -> one cycle later `less`=1, others 0 (both builds).
- REQ-024: a=0xE followed by 252 zeros, b=0xC followed by 252 zeros -> `greater`=1. Then a=0xD followed by 252 zeros, b=0xF followed by 252 zeros -> `less`=1.
- REQ-025: a=1, b=0 (difference only in bit 0, i.e. the lowest slice) -> `greater`=1; a=b=all ones -> `equal`=1.
- REQ-026: Signed build: a = bit 255 set with all else 0, b=1 -> `less`=1; unsigned build, same stimulus -> `greater`=1.
- REQ-027: Back-to-back: apply (5,3), (3,5) and (7,7) on consecutive cycles with MSB=8 and CHUNK=3 -> outputs `greater`, `less`, `equal` on consecutive cycles; check the one-hot property on every cycle.
